// File: rtl/uart_char_tx.sv
// uart_char_tx: 8N1 UART transmitter for the outgoing UCI character stream.
//
// A one-entry staging register accepts the next character while the current
// frame shifts out. The FSM reloads straight from staging at the end of the
// stop bit(s), so consecutive frames leave back-to-back with no idle gap.
//
// Ports:
//   clk_in         system clock
//   rst_n_in       asynchronous active-low reset
//   char_in        character to send, sampled on an accepted transfer
//   char_in_valid  upstream has a character on char_in
//   char_in_ready  staging register empty (registered state only)
//   tx_out         UART serial line, idle high, driven from a flop
//   busy_out       frame on the line or character staged
module uart_char_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] char_in,
  input  logic       char_in_valid,
  output logic       char_in_ready,
  output logic       tx_out,
  output logic       busy_out
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
  // Stop-period counter is one bit wide since at most two stop bits exist.
  localparam logic StopLast = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [7:0]        stage_data_q, stage_data_d;
  logic              stage_valid_q, stage_valid_d;
  logic [7:0]        shift_q, shift_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  assign bit_end       = (baud_q == BaudMax);
  assign char_in_ready = ~stage_valid_q;
  assign busy_out      = (state_q != StIdle) || stage_valid_q;
  assign tx_out        = tx_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= StIdle;
      stage_data_q  <= 8'h00;
      stage_valid_q <= 1'b0;
      shift_q       <= 8'h00;
      baud_q        <= '0;
      bit_idx_q     <= 3'd0;
      stop_cnt_q    <= 1'b0;
      tx_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      stage_data_q  <= stage_data_d;
      stage_valid_q <= stage_valid_d;
      shift_q       <= shift_d;
      baud_q        <= baud_d;
      bit_idx_q     <= bit_idx_d;
      stop_cnt_q    <= stop_cnt_d;
      tx_q          <= tx_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    stage_data_d  = stage_data_q;
    stage_valid_d = stage_valid_q;
    shift_d       = shift_q;
    baud_d        = baud_q;
    bit_idx_d     = bit_idx_q;
    stop_cnt_d    = stop_cnt_q;
    tx_d          = 1'b1;

    // Accept and drain are mutually exclusive: accept needs staging empty,
    // drain needs it full.
    if (char_in_valid && !stage_valid_q) begin
      stage_data_d  = char_in;
      stage_valid_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        baud_d = '0;
        if (stage_valid_q) begin
          shift_d       = stage_data_q;
          stage_valid_d = 1'b0;
          state_d       = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            stop_cnt_d = 1'b0;
            state_d    = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_d = '0;
          if (stop_cnt_q == StopLast) begin
            // Reload directly from staging so the next start bit follows
            // the last stop cycle with no idle cycle in between.
            if (stage_valid_q) begin
              shift_d       = stage_data_q;
              stage_valid_d = 1'b0;
              state_d       = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is registered from the next state so tx_out stays a flop.
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_char_tx.sv
// tb_uart_char_tx: scoreboard bench for uart_char_tx.
// dut1 uses CLKS_PER_BIT=4, STOP_BITS=1 and feeds a line decoder that pops the
// expected-byte queue; dut2 uses STOP_BITS=2 and is checked waveform-wise.
module tb_uart_char_tx;

  localparam int Cpb = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char1 = 8'h00;
  logic [7:0] char2 = 8'h00;
  logic       valid1 = 1'b0;
  logic       valid2 = 1'b0;
  logic       ready1, ready2, tx1, tx2, busy1, busy2;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int         start_log[$];
  int         end_log[$];

  int          cyc = 0;
  bit          rx_act = 1'b0;
  int          rx_p = 0;
  int          rx_shape = 0;
  int          mon_per = 0;
  logic [7:0]  rx_byte = 8'h00;
  logic [31:0] mon_exp = 0;

  always #5 clk = ~clk;

  uart_char_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .char_in       (char1),
    .char_in_valid (valid1),
    .char_in_ready (ready1),
    .tx_out        (tx1),
    .busy_out      (busy1)
  );

  uart_char_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .char_in       (char2),
    .char_in_valid (valid2),
    .char_in_ready (ready2),
    .tx_out        (tx2),
    .busy_out      (busy2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line decoder for dut1: one sample per cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        rx_act = 1'b0;
      end else begin
        if (!rx_act && tx1 === 1'b0) begin
          rx_act   = 1'b1;
          rx_p     = 0;
          rx_shape = 0;
          rx_byte  = 8'h00;
          start_log.push_back(cyc);
        end
        if (rx_act) begin
          mon_per = rx_p / Cpb;
          if (mon_per == 0) begin
            if (tx1 !== 1'b0) rx_shape++;
          end else if (mon_per <= 8) begin
            if (rx_p % Cpb == 0) rx_byte[mon_per-1] = tx1;
            else if (tx1 !== rx_byte[mon_per-1]) rx_shape++;
          end else begin
            if (tx1 !== 1'b1) rx_shape++;
          end
          if (rx_p == 10 * Cpb - 1) begin
            rx_act = 1'b0;
            end_log.push_back(cyc);
            check_eq("frame_shape", rx_shape, 0);
            if (exp_q.size() != 0) mon_exp = {24'h0, exp_q.pop_front()};
            else mon_exp = 32'hdead;
            check_eq("rx_data", rx_byte, mon_exp);
          end else begin
            rx_p++;
          end
        end
      end
    end
  end

  // Drive one character; returns at the falling edge after the accept edge.
  task automatic send(input bit sel, input logic [7:0] b, input bit keep, output int waits);
    waits = 0;
    if (sel) begin char2 = b; valid2 = 1'b1; end
    else begin char1 = b; valid1 = 1'b1; end
    while (((sel ? ready2 : ready1) !== 1'b1) && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) begin
      check_eq("accept_ready", sel ? ready2 : ready1, 1);
    end else begin
      if (!sel) exp_q.push_back(b);
      @(negedge clk);
    end
    if (!keep) begin
      if (sel) valid2 = 1'b0;
      else valid1 = 1'b0;
    end
  endtask

  // Compare tx and busy against the ideal frame, starting at the sample right
  // after the accept edge.
  task automatic wave_check(input string tag, input bit sel, input logic [7:0] b,
                            input int stops);
    int   tx_bad = 0;
    int   busy_cnt = 0;
    int   busy_bad = 0;
    logic tx_s, busy_s, tx_e;
    for (int i = 0; i < 37 + 4 * stops + 4; i++) begin
      if (i > 0) @(negedge clk);
      tx_s   = sel ? tx2 : tx1;
      busy_s = sel ? busy2 : busy1;
      if (i >= 1 && i <= 4) tx_e = 1'b0;
      else if (i >= 5 && i <= 36) tx_e = b[(i - 5) / 4];
      else tx_e = 1'b1;
      if (tx_s !== tx_e) tx_bad++;
      if (busy_s === 1'b1) busy_cnt++;
      if (busy_s !== (i <= 36 + 4 * stops)) busy_bad++;
    end
    check_eq({tag, "_tx"}, tx_bad, 0);
    check_eq({tag, "_busy_len"}, busy_cnt, 37 + 4 * stops);
    check_eq({tag, "_busy_shape"}, busy_bad, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((exp_q.size() != 0 || busy1 || rx_act) && n < budget);
    check_eq("drain_timeout", (n >= budget), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w, s0, bad_tx, bad_rdy, bad_busy, n;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx1, 1);
    check_eq("rst_ready", ready1, 1);
    check_eq("rst_busy", busy1, 0);
    rst_n = 1'b1;

    // Idle with no stimulus
    bad_tx = 0; bad_rdy = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || tx2 !== 1'b1) bad_tx++;
      if (ready1 !== 1'b1 || ready2 !== 1'b1) bad_rdy++;
      if (busy1 !== 1'b0 || busy2 !== 1'b0) bad_busy++;
    end
    check_eq("idle_tx", bad_tx, 0);
    check_eq("idle_ready", bad_rdy, 0);
    check_eq("idle_busy", bad_busy, 0);

    // Single 'A'
    send(1'b0, 8'h41, 1'b0, w);
    wave_check("A", 1'b0, 8'h41, 1);
    wait_idle(200);

    // "ok\n" with valid held, data advanced on each accept
    s0 = start_log.size();
    send(1'b0, 8'h6f, 1'b1, w);
    send(1'b0, 8'h6b, 1'b1, w);
    send(1'b0, 8'h0a, 1'b0, w);
    wait_idle(500);
    check_eq("ok_frames", start_log.size() - s0, 3);
    if (start_log.size() - s0 == 3 && end_log.size() > 0) begin
      check_eq("ok_gap1", start_log[s0+1] - start_log[s0], 40);
      check_eq("ok_gap2", start_log[s0+2] - start_log[s0+1], 40);
      check_eq("ok_span", end_log[end_log.size()-1] - start_log[s0] + 1, 120);
    end

    // Valid held while staging full
    s0 = start_log.size();
    send(1'b0, 8'h11, 1'b0, w);
    send(1'b0, 8'h22, 1'b0, w);
    send(1'b0, 8'h62, 1'b0, w);
    check_eq("full_wait", w, 39);
    wait_idle(500);
    check_eq("full_frames", start_log.size() - s0, 3);

    // Reset during data bit 3 of 0x55
    send(1'b0, 8'h55, 1'b0, w);
    n = 0;
    while (!(rx_act && rx_p >= 17 && rx_p < 20) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("reach_bit3", (n < 200), 1);
    check_eq("bit3_low", tx1, 0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_tx", tx1, 1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_eq("inrst_ready", ready1, 1);
    check_eq("inrst_busy", busy1, 0);
    rst_n = 1'b1;
    s0 = start_log.size();
    @(negedge clk);
    check_eq("post_rst_ready", ready1, 1);
    check_eq("post_rst_busy", busy1, 0);
    repeat (60) @(negedge clk);
    check_eq("no_resume", start_log.size() - s0, 0);
    send(1'b0, 8'h31, 1'b0, w);
    wave_check("post_rst", 1'b0, 8'h31, 1);
    wait_idle(200);

    // Two stop bits
    send(1'b1, 8'hff, 1'b0, w);
    wave_check("stop2", 1'b1, 8'hff, 2);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
